// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - push-button synchronizer, debouncer and press/release/repeat strobe generator
//
// Each button gets an independent channel: a 2-FF synchronizer feeding a
// four-state debounce FSM that emits one-cycle press/release strobes and,
// optionally, auto-repeat strobes while the button stays held.
//
// Ports:
//   CLK          system clock
//   CPU_RESETN   asynchronous active-low reset
//   BTN_IN       raw button levels, 1 = pressed (bit 0=C, 1=L, 2=R, 3=U, 4=D)
//   BTN_LEVEL    debounced level per button
//   BTN_PRESS    one-cycle strobe on accepted press
//   BTN_RELEASE  one-cycle strobe on accepted release
//   BTN_REPEAT   one-cycle auto-repeat strobe while held
//   ANY_PRESS    OR of BTN_PRESS

module button_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_RATE     = 10000000
) (
    input  logic             CLK,
    input  logic             CPU_RESETN,
    input  logic [N_BTN-1:0] BTN_IN,
    output logic [N_BTN-1:0] BTN_LEVEL,
    output logic [N_BTN-1:0] BTN_PRESS,
    output logic [N_BTN-1:0] BTN_RELEASE,
    output logic [N_BTN-1:0] BTN_REPEAT,
    output logic             ANY_PRESS
);

    localparam int CW   = $clog2(DEBOUNCE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX);

    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] ARM_PRESS   = 2'd1;
    localparam logic [1:0] HELD        = 2'd2;
    localparam logic [1:0] ARM_RELEASE = 2'd3;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        logic          s1_q, s2_q;
        logic [1:0]    state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic [RW-1:0] rcnt_q, rcnt_d;
        // 0 = waiting for the first repeat (DELAY), 1 = steady repeats (RATE)
        logic          phase_q, phase_d;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          release_q, release_d;
        logic          repeat_q, repeat_d;

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            rcnt_d    = rcnt_q;
            phase_d   = phase_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            repeat_d  = 1'b0;
            case (state_q)
                IDLE: begin
                    if (s2_q) begin
                        state_d = ARM_PRESS;
                        cnt_d   = '0;
                    end
                end
                ARM_PRESS: begin
                    if (!s2_q) begin
                        state_d = IDLE;
                    end else if (cnt_q == DB_LAST) begin
                        state_d = HELD;
                        press_d = 1'b1;
                        cnt_d   = '0;
                        rcnt_d  = '0;
                        phase_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (!s2_q) begin
                        state_d = ARM_RELEASE;
                        cnt_d   = '0;
                    end else if (REPEAT_EN != 0) begin
                        if (rcnt_q == (phase_q ? RATE_LAST : DELAY_LAST)) begin
                            repeat_d = 1'b1;
                            rcnt_d   = '0;
                            phase_d  = 1'b1;
                        end else begin
                            rcnt_d = rcnt_q + 1'b1;
                        end
                    end
                end
                ARM_RELEASE: begin
                    // rcnt is left untouched here so a bounce resumes the repeat timing
                    if (s2_q) begin
                        state_d = HELD;
                    end else if (cnt_q == DB_LAST) begin
                        state_d   = IDLE;
                        release_d = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            level_d = (state_d == HELD) || (state_d == ARM_RELEASE);
        end

        always_ff @(posedge CLK or negedge CPU_RESETN) begin
            if (!CPU_RESETN) begin
                s1_q      <= 1'b0;
                s2_q      <= 1'b0;
                state_q   <= IDLE;
                cnt_q     <= '0;
                rcnt_q    <= '0;
                phase_q   <= 1'b0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                repeat_q  <= 1'b0;
            end else begin
                s1_q      <= BTN_IN[g];
                s2_q      <= s1_q;
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                rcnt_q    <= rcnt_d;
                phase_q   <= phase_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                repeat_q  <= repeat_d;
            end
        end

        assign BTN_LEVEL[g]   = level_q;
        assign BTN_PRESS[g]   = press_q;
        assign BTN_RELEASE[g] = release_q;
        assign BTN_REPEAT[g]  = repeat_q;
    end

    assign ANY_PRESS = |BTN_PRESS;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner

module tb_button_conditioner;

    localparam int N = 5;

    logic         CLK = 1'b0;
    logic         CPU_RESETN;
    logic [N-1:0] BTN_IN;
    logic [N-1:0] BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_REPEAT;
    logic         ANY_PRESS;
    logic [N-1:0] nr_level, nr_press, nr_release, nr_repeat;
    logic         nr_any;

    button_conditioner #(
        .N_BTN(N), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_RATE(5)
    ) dut (
        .CLK(CLK), .CPU_RESETN(CPU_RESETN), .BTN_IN(BTN_IN),
        .BTN_LEVEL(BTN_LEVEL), .BTN_PRESS(BTN_PRESS), .BTN_RELEASE(BTN_RELEASE),
        .BTN_REPEAT(BTN_REPEAT), .ANY_PRESS(ANY_PRESS)
    );

    button_conditioner #(
        .N_BTN(N), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_RATE(5)
    ) dut_norep (
        .CLK(CLK), .CPU_RESETN(CPU_RESETN), .BTN_IN(BTN_IN),
        .BTN_LEVEL(nr_level), .BTN_PRESS(nr_press), .BTN_RELEASE(nr_release),
        .BTN_REPEAT(nr_repeat), .ANY_PRESS(nr_any)
    );

    always #5 CLK = ~CLK;

    // kinds: 0 press, 1 release, 2 repeat, 3 any_press, 4 norep repeat, 5 norep press
    typedef struct {
        int cyc;
        int kind;
        int b;
    } ev_t;

    ev_t evq[$];
    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    int  c0;
    logic lvl_and;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic log_ev(input int kind, input int b);
        ev_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.b    = b;
        evq.push_back(e);
    endtask

    task automatic step();
        @(negedge CLK);
        cyc++;
        for (int b = 0; b < N; b++) begin
            if (BTN_PRESS[b])   log_ev(0, b);
            if (BTN_RELEASE[b]) log_ev(1, b);
            if (BTN_REPEAT[b])  log_ev(2, b);
            if (nr_repeat[b])   log_ev(4, b);
            if (nr_press[b])    log_ev(5, b);
        end
        if (ANY_PRESS) log_ev(3, 0);
    endtask

    function automatic int count_ev(input int kind, input int b);
        int n = 0;
        foreach (evq[i]) if (evq[i].kind == kind && evq[i].b == b) n++;
        return n;
    endfunction

    function automatic int count_kind(input int kind);
        int n = 0;
        foreach (evq[i]) if (evq[i].kind == kind) n++;
        return n;
    endfunction

    function automatic int count_other(input int b);
        int n = 0;
        foreach (evq[i]) if (evq[i].kind <= 2 && evq[i].b != b) n++;
        return n;
    endfunction

    function automatic int nth_cyc(input int kind, input int b, input int nth);
        int n = 0;
        foreach (evq[i]) begin
            if (evq[i].kind == kind && evq[i].b == b) begin
                if (n == nth) return evq[i].cyc;
                n++;
            end
        end
        return -1;
    endfunction

    initial begin
        CPU_RESETN = 1'b0;
        BTN_IN     = '0;

        // reset state
        repeat (3) step();
        check("rst_level", BTN_LEVEL, 0);
        check("rst_strobes", {BTN_PRESS, BTN_RELEASE, BTN_REPEAT}, 0);
        check("rst_any", ANY_PRESS, 0);
        CPU_RESETN = 1'b1;
        repeat (2) step();

        // clean press on L
        evq.delete();
        c0 = cyc;
        BTN_IN = 5'b00010;
        repeat (6) step();
        check("t1_level_pre", BTN_LEVEL, 0);
        step();
        check("t1_press_vec", BTN_PRESS, 5'b00010);
        check("t1_level", BTN_LEVEL, 5'b00010);
        check("t1_any", ANY_PRESS, 1);
        repeat (13) step();
        BTN_IN = '0;
        repeat (15) step();
        check("t1_press_cnt", count_ev(0, 1), 1);
        check("t1_any_cnt", count_kind(3), 1);
        check("t1_rel_cyc", nth_cyc(1, 1, 0), c0 + 27);
        check("t1_rel_cnt", count_ev(1, 1), 1);
        check("t1_rep0", nth_cyc(2, 1, 0), c0 + 17);
        check("t1_rep1", nth_cyc(2, 1, 1), c0 + 22);
        check("t1_rep_cnt", count_ev(2, 1), 2);
        check("t1_other_bits", count_other(1), 0);
        check("t1_level_end", BTN_LEVEL, 0);

        // press glitch on C
        evq.delete();
        BTN_IN = 5'b00001;
        repeat (3) step();
        BTN_IN = '0;
        repeat (12) step();
        check("t2_events", count_kind(0) + count_kind(1) + count_kind(3), 0);
        check("t2_level", BTN_LEVEL, 0);
        check("t2_idle", dut.g_ch[0].state_q, 0);

        // release bounce on R
        evq.delete();
        c0 = cyc;
        lvl_and = 1'b1;
        BTN_IN = 5'b00100;
        repeat (10) step();
        BTN_IN = '0;
        for (int i = 0; i < 2; i++) begin step(); lvl_and &= BTN_LEVEL[2]; end
        BTN_IN = 5'b00100;
        for (int i = 0; i < 5; i++) begin step(); lvl_and &= BTN_LEVEL[2]; end
        BTN_IN = '0;
        for (int i = 0; i < 6; i++) begin step(); lvl_and &= BTN_LEVEL[2]; end
        repeat (6) step();
        check("t3_level_held", lvl_and, 1);
        check("t3_press_cyc", nth_cyc(0, 2, 0), c0 + 7);
        check("t3_press_cnt", count_ev(0, 2), 1);
        check("t3_rel_cyc", nth_cyc(1, 2, 0), c0 + 24);
        check("t3_rel_cnt", count_ev(1, 2), 1);
        check("t3_rep_cnt", count_ev(2, 2), 0);
        check("t3_level_end", BTN_LEVEL, 0);

        // auto-repeat on U, plus REPEAT_EN=0 instance
        evq.delete();
        c0 = cyc;
        BTN_IN = 5'b01000;
        repeat (38) step();
        BTN_IN = '0;
        repeat (12) step();
        check("t4_press_cyc", nth_cyc(0, 3, 0), c0 + 7);
        for (int n = 0; n < 5; n++) check($sformatf("t4_rep%0d", n), nth_cyc(2, 3, n), c0 + 17 + 5 * n);
        check("t4_rep_cnt", count_ev(2, 3), 5);
        check("t4_rel_cyc", nth_cyc(1, 3, 0), c0 + 45);
        check("t4_norep_rep", count_kind(4), 0);
        check("t4_norep_press", nth_cyc(5, 3, 0), c0 + 7);

        // simultaneous C and D
        evq.delete();
        BTN_IN = 5'b10001;
        repeat (6) step();
        check("t5_press_pre", BTN_PRESS, 0);
        step();
        check("t5_press_vec", BTN_PRESS, 5'b10001);
        check("t5_any", ANY_PRESS, 1);
        step();
        check("t5_press_post", BTN_PRESS, 0);
        check("t5_any_post", ANY_PRESS, 0);
        BTN_IN = '0;
        repeat (12) step();
        check("t5_any_cnt", count_kind(3), 1);
        check("t5_rel_b0", count_ev(1, 0), 1);
        check("t5_rel_b4", count_ev(1, 4), 1);

        // async reset during ARM_PRESS, then during HELD
        BTN_IN = 5'b00010;
        repeat (3) step();
        #2 CPU_RESETN = 1'b0;
        #1;
        check("t6a_outs", {BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_REPEAT}, 0);
        check("t6a_idle", dut.g_ch[1].state_q, 0);
        repeat (2) step();
        CPU_RESETN = 1'b1;
        evq.delete();
        c0 = cyc;
        repeat (6) step();
        check("t6b_press_pre", BTN_PRESS, 0);
        step();
        check("t6b_press", BTN_PRESS, 5'b00010);
        #2 CPU_RESETN = 1'b0;
        #1;
        check("t6c_outs", {BTN_LEVEL, BTN_PRESS, BTN_RELEASE, BTN_REPEAT}, 0);
        check("t6c_any", ANY_PRESS, 0);
        BTN_IN = '0;
        repeat (2) step();
        CPU_RESETN = 1'b1;
        evq.delete();
        repeat (15) step();
        check("t6d_no_pending", evq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
